ysyx_22050039_ifu: RTL and testbench

YSYX_22050039_IFU -- requirements
Module: ysyx_22050039_ifu

---
 rtl/ysyx_22050039_ifu_pkg.sv | 21 ++
 rtl/ysyx_22050039_ifu_fsm.sv | 77 +++++++
 rtl/ysyx_22050039_ifu.sv | 97 +++++++++
 tb/tb_ysyx_22050039_ifu.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050039_ifu_pkg.sv
// Shared IFU definitions: FSM state encoding, reset PC
// and instruction geometry used by the fetch unit.
package ysyx_22050039_ifu_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } ifu_state_e;

    localparam logic [63:0] IFU_RESET_PC   = 64'h8000_0000;
    localparam int          IFU_INST_LEN   = 32;
    localparam int          IFU_INST_ALIGN = 4;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_22050039_ifu_fsm.sv
// Fetch-unit control: state register, next-state logic and
// registered handshake outputs for memory and decode.
module ysyx_22050039_ifu_fsm
    import ysyx_22050039_ifu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_pc_wen,
    input  logic       i_mem_req_ready,
    input  logic       i_mem_resp_valid,
    input  logic       i_inst_ready,
    output ifu_state_e o_state,
    output logic       o_req_valid,
    output logic       o_inst_valid,
    output logic       o_latch,
    output logic       o_consume
);

    ifu_state_e r_state;
    ifu_state_e w_next;
    logic       r_req_valid;
    logic       r_inst_valid;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: w_next = S_REQ;
            S_REQ: begin
                if (i_pc_wen && i_mem_req_ready)
                    w_next = S_DROP;
                else if (i_pc_wen)
                    w_next = S_REQ;
                else if (i_mem_req_ready)
                    w_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_pc_wen && i_mem_resp_valid)
                    w_next = S_REQ;
                else if (i_pc_wen)
                    w_next = S_DROP;
                else if (i_mem_resp_valid)
                    w_next = S_HOLD;
            end
            S_HOLD: begin
                if (i_pc_wen || i_inst_ready)
                    w_next = S_REQ;
            end
            S_DROP: begin
                // The stale response still owed by memory is swallowed here
                if (i_mem_resp_valid)
                    w_next = S_REQ;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_req_valid  <= (w_next == S_REQ);
            r_inst_valid <= (w_next == S_HOLD);
        end
    end

    assign o_state      = r_state;
    assign o_req_valid  = r_req_valid;
    assign o_inst_valid = r_inst_valid;
    assign o_latch      = (r_state == S_WAIT) && i_mem_resp_valid
                          && !i_pc_wen;
    assign o_consume    = (r_state == S_HOLD) && i_inst_ready
                          && !i_pc_wen;

endmodule

// File: rtl/ysyx_22050039_ifu.sv
// Instruction fetch unit: issues one fetch at a time, holds the
// result for decode and follows redirects from later stages.
module ysyx_22050039_ifu
    import ysyx_22050039_ifu_pkg::*;
#(
    parameter int                XLEN     = 64,
    parameter int                INST_LEN = IFU_INST_LEN,
    parameter logic [XLEN-1:0]   RESET_PC = IFU_RESET_PC[XLEN-1:0]
) (
    input  logic                clk,
    input  logic                rst,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [XLEN-1:0]     mem_req_addr,
    input  logic                mem_resp_valid,
    input  logic [INST_LEN-1:0] mem_resp_data,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [INST_LEN-1:0] inst,
    output logic [XLEN-1:0]     pc,
    input  logic                pc_wen,
    input  logic [XLEN-1:0]     pc_wdata,
    output logic                misalign,
    output logic [XLEN-1:0]     fetch_cnt
);

    ifu_state_e          w_state;
    logic                w_req_valid;
    logic                w_inst_valid;
    logic                w_latch;
    logic                w_consume;
    logic [XLEN-1:0]     w_redirect_pc;

    logic [XLEN-1:0]     r_pc;
    logic [INST_LEN-1:0] r_inst;
    logic [XLEN-1:0]     r_cnt;
    logic                r_misalign;

    ysyx_22050039_ifu_fsm u_fsm (
        .clk              (clk),
        .rst              (rst),
        .i_pc_wen         (pc_wen),
        .i_mem_req_ready  (mem_req_ready),
        .i_mem_resp_valid (mem_resp_valid),
        .i_inst_ready     (inst_ready),
        .o_state          (w_state),
        .o_req_valid      (w_req_valid),
        .o_inst_valid     (w_inst_valid),
        .o_latch          (w_latch),
        .o_consume        (w_consume)
    );

    assign w_redirect_pc = {pc_wdata[XLEN-1:2], 2'b00};

    // Redirect wins over the sequential +4 step
    always_ff @(posedge clk) begin
        if (rst)
            r_pc <= RESET_PC;
        else if (pc_wen)
            r_pc <= w_redirect_pc;
        else if (w_consume)
            r_pc <= r_pc + XLEN'(IFU_INST_ALIGN);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_inst <= '0;
        else if (w_latch)
            r_inst <= mem_resp_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_consume)
            r_cnt <= r_cnt + XLEN'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_misalign <= 1'b0;
        else
            r_misalign <= pc_wen && is_misaligned(pc_wdata[1:0]);
    end

    logic w_unused;
    assign w_unused = (w_state == S_IDLE);

    assign mem_req_valid = w_req_valid;
    assign mem_req_addr  = r_pc;
    assign inst_valid    = w_inst_valid;
    assign inst          = r_inst;
    assign pc            = r_pc;
    assign misalign      = r_misalign;
    assign fetch_cnt     = r_cnt;

endmodule

// File: tb/tb_ysyx_22050039_ifu.sv
// Directed bench for the fetch unit with a one-cycle memory
// model driven from the stimulus process.
module tb_ysyx_22050039_ifu;

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        pc_wen;
    logic [63:0] pc_wdata;
    logic        misalign;
    logic [63:0] fetch_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit auto_mem = 1'b1;

    ysyx_22050039_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .pc_wen         (pc_wen),
        .pc_wdata       (pc_wdata),
        .misalign       (misalign),
        .fetch_cnt      (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [63:0] a);
        return a[31:0] ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; the memory answers the cycle after a handshake
    task automatic tick();
        logic        acc;
        logic [63:0] a;
        acc = mem_req_valid && mem_req_ready && !rst;
        a   = mem_req_addr;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            mem_resp_valid = acc;
            mem_resp_data  = acc ? mk(a) : 32'h0;
        end
    endtask

    initial begin
        rst            = 1'b1;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        inst_ready     = 1'b0;
        pc_wen         = 1'b0;
        pc_wdata       = 64'h0;

        tick();
        tick();
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_pc", pc, 64'h8000_0000);
        check("rst_cnt", fetch_cnt, 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);

        rst        = 1'b0;
        inst_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("seq_req_valid", 64'(mem_req_valid), 64'd1);
            check("seq_addr", mem_req_addr, 64'h8000_0000 + 64'(4 * i));
            tick();
            check("seq_wait_iv", 64'(inst_valid), 64'd0);
            tick();
            check("seq_hold_iv", 64'(inst_valid), 64'd1);
            check("seq_inst", 64'(inst),
                  64'(mk(64'h8000_0000 + 64'(4 * i))));
            tick();
        end
        check("seq_cnt", fetch_cnt, 64'd3);
        check("seq_next_addr", mem_req_addr, 64'h8000_000C);

        inst_ready = 1'b0;
        tick();
        tick();
        check("stall_iv", 64'(inst_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_inst", 64'(inst), 64'(mk(64'h8000_000C)));
            check("stall_pc", pc, 64'h8000_000C);
            check("stall_req", 64'(mem_req_valid), 64'd0);
            check("stall_cnt", fetch_cnt, 64'd3);
        end
        inst_ready = 1'b1;
        tick();
        check("stall_cnt_after", fetch_cnt, 64'd4);
        check("stall_addr_after", mem_req_addr, 64'h8000_0010);

        auto_mem       = 1'b0;
        mem_resp_valid = 1'b0;
        tick();
        pc_wen   = 1'b1;
        pc_wdata = 64'h8000_1000;
        tick();
        pc_wen = 1'b0;
        check("drop_req", 64'(mem_req_valid), 64'd0);
        check("drop_pc", pc, 64'h8000_1000);
        tick();
        check("drop_wait_req", 64'(mem_req_valid), 64'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        tick();
        mem_resp_valid = 1'b0;
        auto_mem       = 1'b1;
        check("drop_iv", 64'(inst_valid), 64'd0);
        check("drop_inst_kept", 64'(inst), 64'(mk(64'h8000_000C)));
        check("drop_new_addr", mem_req_addr, 64'h8000_1000);
        check("drop_new_req", 64'(mem_req_valid), 64'd1);
        tick();
        tick();
        check("redir_inst", 64'(inst), 64'(mk(64'h8000_1000)));
        tick();
        check("redir_cnt", fetch_cnt, 64'd5);

        mem_req_ready = 1'b0;
        pc_wen        = 1'b1;
        pc_wdata      = 64'h8000_0102;
        tick();
        pc_wen        = 1'b0;
        mem_req_ready = 1'b1;
        check("mis_pulse", 64'(misalign), 64'd1);
        check("mis_addr", mem_req_addr, 64'h8000_0100);
        tick();
        check("mis_clear", 64'(misalign), 64'd0);
        tick();
        check("mis_inst", 64'(inst), 64'(mk(64'h8000_0100)));
        tick();
        check("mis_cnt", fetch_cnt, 64'd6);

        tick();
        tick();
        check("hold_redir_iv", 64'(inst_valid), 64'd1);
        pc_wen   = 1'b1;
        pc_wdata = 64'h8000_2000;
        tick();
        pc_wen = 1'b0;
        check("hold_redir_cnt", fetch_cnt, 64'd6);
        check("hold_redir_addr", mem_req_addr, 64'h8000_2000);
        check("hold_redir_req", 64'(mem_req_valid), 64'd1);

        mem_req_ready = 1'b0;
        pc_wen        = 1'b1;
        pc_wdata      = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        pc_wen        = 1'b0;
        mem_req_ready = 1'b1;
        check("wrap_addr_top", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        tick();
        check("wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("wrap_addr_zero", mem_req_addr, 64'h0);
        check("wrap_cnt", fetch_cnt, 64'd7);

        auto_mem       = 1'b0;
        mem_resp_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("mrst_req", 64'(mem_req_valid), 64'd0);
        check("mrst_pc", pc, 64'h8000_0000);
        check("mrst_cnt", fetch_cnt, 64'd0);
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h1234_5678;
        tick();
        mem_resp_valid = 1'b0;
        check("mrst_first_req", 64'(mem_req_valid), 64'd1);
        check("mrst_first_addr", mem_req_addr, 64'h8000_0000);
        check("mrst_iv", 64'(inst_valid), 64'd0);
        check("mrst_inst", 64'(inst), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
